// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and pipe_hazard_ctrl.
// PIPE_STATS_EN adds the flush/bubble statistics counters.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic             d_ren_o2;
  logic [REG_W-1:0] wsel_o2;
  logic [REG_W-1:0] rsel1_i2;
  logic [REG_W-1:0] rsel2_i2;
  logic             d_ren_o3;
  logic             d_wen_o3;
  logic             take_o3;
  logic             halt_o3;
  logic             pipe1_en;
  logic             pipe2_en;
  logic             pipe3_en;
  logic             pipe4_en;
  logic             flushed1;
  logic             flushed2;
  logic             flushed3;
  logic             pc_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  // Datapath side.
  modport master (
    output ihit, dhit, d_ren_o2, wsel_o2, rsel1_i2, rsel2_i2,
    output d_ren_o3, d_wen_o3, take_o3, halt_o3,
    input  pipe1_en, pipe2_en, pipe3_en, pipe4_en, flushed1, flushed2, flushed3,
    input  pc_en, halted, stall_cnt
`ifdef PIPE_STATS_EN
    , input flush_cnt, bubble_cnt
`endif
  );

  // Hazard controller side.
  modport slave (
    input  ihit, dhit, d_ren_o2, wsel_o2, rsel1_i2, rsel2_i2,
    input  d_ren_o3, d_wen_o3, take_o3, halt_o3,
    output pipe1_en, pipe2_en, pipe3_en, pipe4_en, flushed1, flushed2, flushed3,
    output pc_en, halted, stall_cnt
`ifdef PIPE_STATS_EN
    , output flush_cnt, bubble_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes, PC enable, halt latch, stall stats.
// Define PIPE_STATS_EN to add saturating flush and bubble counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input logic              CLK,
  input logic              nRST,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {StRun, StDwait, StHalt} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [REG_W-1:0] wsel;
  logic             memreq, mstall, lu;
  logic [3:0]       pipe_en;
  logic [2:0]       flushed;
  logic             pc_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] flush_q, flush_d, bubble_q, bubble_d;
`endif

  assign wsel = bus.wsel_o2;

  always_comb begin
    memreq  = bus.d_ren_o3 | bus.d_wen_o3;
    mstall  = memreq & ~bus.dhit;
    // Register zero is never a real producer.
    lu      = bus.d_ren_o2 & (wsel != '0) & ((wsel == bus.rsel1_i2) | (wsel == bus.rsel2_i2));
    pipe_en = 4'b1111;
    flushed = 3'b000;
    pc_en   = 1'b1;
    state_d = state_q;
    stall_d = stall_q;
`ifdef PIPE_STATS_EN
    flush_d  = flush_q;
    bubble_d = bubble_q;
`endif
    if (state_q == StHalt) begin
      pipe_en = 4'b0000;
      pc_en   = 1'b0;
    end else if (mstall) begin
      pipe_en = 4'b0000;
      pc_en   = 1'b0;
      state_d = StDwait;
      stall_d = sat_inc(stall_q);
    end else begin
      // Halt only latches once the EX/MEM stage is free to advance.
      state_d = bus.halt_o3 ? StHalt : StRun;
      if (bus.take_o3) begin
        flushed = 3'b111;
`ifdef PIPE_STATS_EN
        flush_d = sat_inc(flush_q);
`endif
      end else if (lu) begin
        pipe_en[0] = 1'b0;
        pc_en      = 1'b0;
        flushed[1] = 1'b1;
`ifdef PIPE_STATS_EN
        bubble_d = sat_inc(bubble_q);
`endif
      end else if (!bus.ihit) begin
        flushed[0] = 1'b1;
        pc_en      = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StRun;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

`ifdef PIPE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      flush_q  <= flush_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.flush_cnt  = flush_q;
  assign bus.bubble_cnt = bubble_q;
`endif

  assign bus.pipe1_en  = pipe_en[0];
  assign bus.pipe2_en  = pipe_en[1];
  assign bus.pipe3_en  = pipe_en[2];
  assign bus.pipe4_en  = pipe_en[3];
  assign bus.flushed1  = flushed[0];
  assign bus.flushed2  = flushed[1];
  assign bus.flushed3  = flushed[2];
  assign bus.pc_en     = pc_en;
  assign bus.halted    = (state_q == StHalt);
  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a behavioural priority model.
// Define PIPE_STATS_EN to also cover the flush/bubble counters.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  // Model state: halted flag and plain integer statistics.
  bit m_halted;
  int m_stall, m_flush, m_bubble;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W), .REG_W(REG_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Observed vector: {pipe1..4_en, flushed1..3, pc_en, halted}.
  function automatic logic [8:0] obs();
    return {bus.pipe1_en, bus.pipe2_en, bus.pipe3_en, bus.pipe4_en,
            bus.flushed1, bus.flushed2, bus.flushed3, bus.pc_en, bus.halted};
  endfunction

  function automatic bit m_mstall();
    return (bus.d_ren_o3 || bus.d_wen_o3) && !bus.dhit;
  endfunction

  function automatic bit m_lu();
    return bus.d_ren_o2 && bus.wsel_o2 != 0 &&
           (bus.wsel_o2 == bus.rsel1_i2 || bus.wsel_o2 == bus.rsel2_i2);
  endfunction

  function automatic logic [8:0] model_out();
    if (m_halted)          return 9'b0000_000_0_1;
    else if (m_mstall())   return 9'b0000_000_0_0;
    else if (bus.take_o3)  return 9'b1111_111_1_0;
    else if (m_lu())       return 9'b0111_010_0_0;
    else if (!bus.ihit)    return 9'b1111_100_0_0;
    else                   return 9'b1111_000_1_0;
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_halted = 0; m_stall = 0; m_flush = 0; m_bubble = 0;
  endtask

  // Advance model for the upcoming edge, then move to the next negedge.
  task automatic cycle();
    if (!m_halted) begin
      if (m_mstall()) m_stall = sat(m_stall);
      else begin
        if (bus.take_o3) m_flush = sat(m_flush);
        else if (m_lu()) m_bubble = sat(m_bubble);
        if (bus.halt_o3) m_halted = 1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    bus.ihit = 1; bus.dhit = 0; bus.d_ren_o2 = 0; bus.wsel_o2 = 0;
    bus.rsel1_i2 = 0; bus.rsel2_i2 = 0; bus.d_ren_o3 = 0; bus.d_wen_o3 = 0;
    bus.take_o3 = 0; bus.halt_o3 = 0;
  endtask

  task automatic do_reset();
    idle();
    nRST = 0;
    model_clear();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (obs() !== 9'b1111_000_1_0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs(), 9'b1111_000_1_0);
    end
    checks++;
    if (bus.stall_cnt !== 0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    bus.d_ren_o3 = 1; bus.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs() !== 9'b0000_000_0_0) begin
        errors++; $display("FAIL mstall_cycle%0d: got %b want %b", i, obs(), 9'b0000_000_0_0);
      end
      cycle();
    end
    bus.dhit = 1;
    #1;
    checks++;
    if (bus.stall_cnt !== 3) begin
      errors++; $display("FAIL mstall_count: got %0d want 3", bus.stall_cnt);
    end
    checks++;
    if (obs() !== 9'b1111_000_1_0) begin
      errors++; $display("FAIL mstall_release: got %b want %b", obs(), 9'b1111_000_1_0);
    end
    cycle();
    // Back in RUN: a lone fetch miss must show its own pattern, not a stall.
    bus.d_ren_o3 = 0; bus.ihit = 0;
    #1;
    checks++;
    if (obs() !== 9'b1111_100_0_0) begin
      errors++; $display("FAIL mstall_then_imiss: got %b want %b", obs(), 9'b1111_100_0_0);
    end
    cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.d_ren_o2 = 1; bus.wsel_o2 = 5; bus.rsel2_i2 = 5; bus.rsel1_i2 = 3;
    #1;
    checks++;
    if (obs() !== 9'b0111_010_0_0) begin
      errors++; $display("FAIL load_use_rs2: got %b want %b", obs(), 9'b0111_010_0_0);
    end
    bus.rsel2_i2 = 2; bus.rsel1_i2 = 5;
    #1;
    checks++;
    if (obs() !== 9'b0111_010_0_0) begin
      errors++; $display("FAIL load_use_rs1: got %b want %b", obs(), 9'b0111_010_0_0);
    end
    bus.wsel_o2 = 0; bus.rsel1_i2 = 0; bus.rsel2_i2 = 0;
    #1;
    checks++;
    if (obs() !== 9'b1111_000_1_0) begin
      errors++; $display("FAIL load_use_r0: got %b want %b", obs(), 9'b1111_000_1_0);
    end
    cycle();
  endtask

  task automatic test_take_priority();
    do_reset();
    bus.take_o3 = 1; bus.d_ren_o2 = 1; bus.wsel_o2 = 7; bus.rsel1_i2 = 7; bus.ihit = 0;
    #1;
    checks++;
    if (obs() !== 9'b1111_111_1_0) begin
      errors++; $display("FAIL take_over_lu_imiss: got %b want %b", obs(), 9'b1111_111_1_0);
    end
    cycle();
  endtask

  task automatic test_halt();
    do_reset();
    bus.halt_o3 = 1; bus.take_o3 = 1; bus.d_wen_o3 = 1; bus.dhit = 0;
    #1;
    checks++;
    if (obs() !== 9'b0000_000_0_0) begin
      errors++; $display("FAIL halt_stalled: got %b want %b", obs(), 9'b0000_000_0_0);
    end
    cycle();
    bus.dhit = 1;
    #1;
    checks++;
    if (obs() !== 9'b1111_111_1_0) begin
      errors++; $display("FAIL halt_dhit_cycle: got %b want %b", obs(), 9'b1111_111_1_0);
    end
    cycle();
    for (int i = 0; i < 5; i++) begin
      bus.ihit = 1'($urandom); bus.dhit = 1'($urandom); bus.d_ren_o3 = 1'($urandom);
      bus.take_o3 = 1'($urandom); bus.halt_o3 = 1'($urandom);
      #1;
      checks++;
      if (obs() !== 9'b0000_000_0_1) begin
        errors++; $display("FAIL halted_hold%0d: got %b want %b", i, obs(), 9'b0000_000_0_1);
      end
      cycle();
    end
    checks++;
    if (bus.stall_cnt !== 1) begin
      errors++; $display("FAIL halt_stall_cnt: got %0d want 1", bus.stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.ihit     = ($urandom_range(0, 3) != 0);
      bus.dhit     = 1'($urandom);
      bus.d_ren_o3 = ($urandom_range(0, 3) == 0);
      bus.d_wen_o3 = ($urandom_range(0, 5) == 0);
      bus.take_o3  = ($urandom_range(0, 5) == 0);
      bus.halt_o3  = ($urandom_range(0, 60) == 0);
      bus.d_ren_o2 = 1'($urandom);
      bus.wsel_o2  = REG_W'($urandom_range(0, 3));
      bus.rsel1_i2 = REG_W'($urandom_range(0, 3));
      bus.rsel2_i2 = REG_W'($urandom_range(0, 3));
      #1;
      checks++;
      if (obs() !== model_out() || bus.stall_cnt !== CNT_W'(m_stall)) begin
        errors++;
        $display("FAIL random%0d: got %b cnt %0d want %b cnt %0d",
                 i, obs(), bus.stall_cnt, model_out(), m_stall);
      end
`ifdef PIPE_STATS_EN
      checks++;
      if (bus.flush_cnt !== CNT_W'(m_flush) || bus.bubble_cnt !== CNT_W'(m_bubble)) begin
        errors++;
        $display("FAIL random_stats%0d: got %0d/%0d want %0d/%0d",
                 i, bus.flush_cnt, bus.bubble_cnt, m_flush, m_bubble);
      end
`endif
      cycle();
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.take_o3 = 1;
    cycle();
    bus.take_o3 = 0; bus.d_ren_o2 = 1; bus.wsel_o2 = 4; bus.rsel1_i2 = 4;
    cycle();
    bus.d_ren_o2 = 0; bus.d_wen_o3 = 1; bus.dhit = 0;
    cycle();
    cycle();
    #1;
    nRST = 0;
    model_clear();
    #1;
    checks++;
    if (bus.stall_cnt !== 0 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: got cnt %0d halted %b want 0 0",
                         bus.stall_cnt, bus.halted);
    end
`ifdef PIPE_STATS_EN
    checks++;
    if (bus.flush_cnt !== 0 || bus.bubble_cnt !== 0) begin
      errors++; $display("FAIL reset_mid_stall_stats: got %0d/%0d want 0/0",
                         bus.flush_cnt, bus.bubble_cnt);
    end
`endif
    @(negedge CLK);
    idle();
    nRST = 1;
    #1;
    checks++;
    if (obs() !== 9'b1111_000_1_0) begin
      errors++; $display("FAIL reset_mid_stall_run: got %b want %b", obs(), 9'b1111_000_1_0);
    end
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.take_o3 = 1;
      cycle();
      bus.take_o3 = 0;
      cycle();
    end
    bus.d_ren_o2 = 1; bus.wsel_o2 = 6; bus.rsel2_i2 = 6;
    for (int i = 0; i < 3; i++) cycle();
    // Stalled load-use must not count.
    bus.d_ren_o3 = 1; bus.dhit = 0;
    cycle();
    idle();
    #1;
    checks++;
    if (bus.flush_cnt !== 2 || bus.bubble_cnt !== 3) begin
      errors++; $display("FAIL stats_counts: got %0d/%0d want 2/3",
                         bus.flush_cnt, bus.bubble_cnt);
    end
    cycle();
  endtask
`endif

  initial begin
    idle();
    nRST = 0;
    @(negedge CLK);
    test_reset();
    test_mem_stall();
    test_load_use();
    test_take_priority();
    test_halt();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the control side of the four pipeline latches: pipe1_en..pipe4_en, flushed1..flushed3, plus the PC write enable.
- Sits beside the datapath.
- Consumes latch outputs, decode register selects and cache hit signals.
- Resolves four hazard classes: memory stall, taken control transfer in MEM, load-use, and instruction-fetch miss.
- Owns the halt latch and stall/flush statistics.

Parameters:
- CNT_W, 16, width of the saturating statistics counters.
- REG_W, 5, register select width; matches regbits_t.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch complete this cycle.
- dhit  input  1  data access complete this cycle.
- d_ren_o2  input  1  load sitting in EX (DC/EX latch output).
- wsel_o2  input  REG_W  EX destination register.
- rsel1_i2  input  REG_W  decode source register 1.
- rsel2_i2  input  REG_W  decode source register 2.
- d_ren_o3  input  1  MEM-stage read request (EX/MEM latch output).
- d_wen_o3  input  1  MEM-stage write request (EX/MEM latch output).
- take_o3  input  1  branch/jump/jr resolved taken in MEM.
- halt_o3  input  1  halt instruction in MEM.
- pipe1_en  output  1  IF/DC latch enable.
- pipe2_en  output  1  DC/EX latch enable.
- pipe3_en  output  1  EX/MEM latch enable.
- pipe4_en  output  1  MEM/WB latch enable.
- flushed1  output  1  IF/DC latch loads a bubble.
- flushed2  output  1  DC/EX latch loads a bubble.
- flushed3  output  1  EX/MEM latch loads a bubble.
- pc_en  output  1  PC register update enable.
- halted  output  1  sticky halt, to the system.
- stall_cnt  output  CNT_W  saturating count of memory-stall cycles.

Behaviour:
- State register, encoded RUN / DWAIT / HALT. On nRST low: state=RUN, stall_cnt=0, halted=0.
- Outputs are combinational from state and inputs, so latches and PC sample them on the same edge.
- Default values: pipe*_en=1, flushed*=0, pc_en=1.
- Derived terms:
  - memreq = d_ren_o3 | d_wen_o3.
  - mstall = memreq & !dhit.
  - lu = d_ren_o2 & (wsel_o2!=0) & (wsel_o2==rsel1_i2 | wsel_o2==rsel2_i2).
- Priority, highest first:
  - HALT: all pipe*_en=0, pc_en=0, flushed*=0, halted=1. Exit only by reset.
  - mstall (in RUN or DWAIT): all pipe*_en=0, pc_en=0. Next state=DWAIT. stall_cnt+1, saturating at all-ones.
  - take_o3: enables=1, flushed1=flushed2=flushed3=1, pc_en=1 (PC loads target).
    - A simultaneous lu or !ihit is ignored; those instructions are squashed anyway.
  - lu: pipe1_en=0, pc_en=0, flushed2=1 (bubble into EX); pipe2..4_en=1.
  - !ihit: pipe1_en=1, flushed1=1, pc_en=0; downstream stages advance.
  - Otherwise: defaults.
- Transitions:
  - DWAIT -> RUN on the first cycle with dhit=1. That cycle the pipe advances normally, and lower-priority hazards apply in the same cycle.
  - Any state except HALT -> HALT at the edge where halt_o3=1 and pipe3 is not stalled (mstall=0). halted asserts the following cycle.
- halt_o3 together with take_o3: halt wins at the next edge; the flushes in the current cycle still occur.
- wsel_o2=0 never raises lu (register zero).
- nRST assertion mid-stall: immediate return to RUN, counters cleared, halted cleared.

Optional Feature:
- Macro: PIPE_STATS_EN.
- When defined, adds outputs flush_cnt[CNT_W] and bubble_cnt[CNT_W]. Both are saturating and cleared by nRST.
  - flush_cnt increments each cycle the take_o3 branch of the priority applies.
  - bubble_cnt increments each cycle the lu branch applies.
  - Neither increments in HALT or during mstall.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, ihit=1, dhit=0, no mem op -> all pipe*_en=1, flushed*=0, pc_en=1, stall_cnt=0, halted=0.
- d_ren_o3=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 for 3 cycles with stall_cnt=3; on the dhit cycle enables=1 and state returns to RUN.
- d_ren_o2=1, wsel_o2=5, rsel2_i2=5 -> pipe1_en=0, pc_en=0, flushed2=1, pipe2..4_en=1.
  - Same stimulus with wsel_o2=0 -> no stall.
- take_o3=1 together with lu and ihit=0 -> flushed1..3=1, pc_en=1, all enables 1.
- halt_o3=1, d_wen_o3=1, dhit=0 for 1 cycle, then dhit=1 -> halted rises only after the dhit edge; all enables then stay 0 indefinitely.
- With PIPE_STATS_EN: 2 taken branches and 3 load-use cycles -> flush_cnt=2, bubble_cnt=3. Pulse nRST low mid-DWAIT -> all counters 0, state RUN.
